// File: rtl/axis_ifg_shaper.sv
// AXI-Stream register slice with a skid buffer, a programmable idle gap inserted after
// each packet, tkeep framing checks and downstream packet/byte counters.
module axis_ifg_shaper #(
  parameter int TDATA_WIDTH = 512,
  parameter int GAP_WIDTH   = 16,
  parameter int CNT_WIDTH   = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  input  logic [GAP_WIDTH-1:0]       gap_cycles,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic [CNT_WIDTH-1:0]       byte_count,
  output logic                       err_keep
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    PASS = 1'b0,
    GAP  = 1'b1
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [CNT_WIDTH-1:0] n;
    n = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      n = n + {{(CNT_WIDTH-1){1'b0}}, keep[i]};
    end
    return n;
  endfunction

  // A last beat must be a non-empty run of ones from the LSB; other beats must be full.
  function automatic logic keep_bad(input logic [KEEP_WIDTH-1:0] keep, input logic last);
    logic [KEEP_WIDTH-1:0] keep_inc;
    logic                  bad;
    keep_inc = keep + {{(KEEP_WIDTH-1){1'b0}}, 1'b1};
    if (!last) begin
      bad = (keep != {KEEP_WIDTH{1'b1}});
    end else begin
      bad = (keep == {KEEP_WIDTH{1'b0}}) || ((keep & keep_inc) != {KEEP_WIDTH{1'b0}});
    end
    return bad;
  endfunction

  state_t                  state_r;
  logic [GAP_WIDTH-1:0]    cnt_r;
  logic [TDATA_WIDTH-1:0]  m_data_r;
  logic [KEEP_WIDTH-1:0]   m_keep_r;
  logic                    m_last_r;
  logic                    m_valid_r;
  logic [TDATA_WIDTH-1:0]  skid_data_r;
  logic [KEEP_WIDTH-1:0]   skid_keep_r;
  logic                    skid_last_r;
  logic                    skid_valid_r;
  logic                    s_ready_r;
  logic [CNT_WIDTH-1:0]    pkt_count_r;
  logic [CNT_WIDTH-1:0]    byte_count_r;
  logic                    err_keep_r;

  logic m_hs_s;
  logic s_hs_s;
  logic gap_start_s;
  logic load_ok_s;
  logic out_free_s;
  logic take_skid_s;
  logic take_in_s;
  logic fill_skid_s;
  logic skid_valid_nxt_s;

  // Handshake decode and steering of the incoming beat between output and skid registers.
  always_comb begin
    m_hs_s      = m_valid_r & m_axis_tready;
    s_hs_s      = s_axis_tvalid & s_ready_r;
    gap_start_s = m_hs_s & m_last_r & (gap_cycles != {GAP_WIDTH{1'b0}});
    out_free_s  = ~m_valid_r | m_axis_tready;
    // In GAP the output may only be reloaded on the final gap cycle.
    if (state_r == PASS) begin
      load_ok_s = ~gap_start_s;
    end else begin
      load_ok_s = (cnt_r == GAP_ONE);
    end
    take_skid_s = out_free_s & load_ok_s & skid_valid_r;
    take_in_s   = out_free_s & load_ok_s & ~skid_valid_r & s_hs_s;
    fill_skid_s = s_hs_s & ~take_in_s;
    if (take_skid_s) begin
      skid_valid_nxt_s = 1'b0;
    end else begin
      skid_valid_nxt_s = skid_valid_r | fill_skid_s;
    end
  end

  // Gap FSM, datapath registers, counters and framing flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= PASS;
      cnt_r        <= {GAP_WIDTH{1'b0}};
      m_data_r     <= {TDATA_WIDTH{1'b0}};
      m_keep_r     <= {KEEP_WIDTH{1'b0}};
      m_last_r     <= 1'b0;
      m_valid_r    <= 1'b0;
      skid_data_r  <= {TDATA_WIDTH{1'b0}};
      skid_keep_r  <= {KEEP_WIDTH{1'b0}};
      skid_last_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      s_ready_r    <= 1'b0;
      pkt_count_r  <= {CNT_WIDTH{1'b0}};
      byte_count_r <= {CNT_WIDTH{1'b0}};
      err_keep_r   <= 1'b0;
    end else begin
      case (state_r)
        PASS: begin
          if (gap_start_s) begin
            state_r <= GAP;
            cnt_r   <= gap_cycles;
          end
        end
        GAP: begin
          if (cnt_r == GAP_ONE) begin
            state_r <= PASS;
          end
          cnt_r <= cnt_r - GAP_ONE;
        end
        default: begin
          state_r <= PASS;
          cnt_r   <= {GAP_WIDTH{1'b0}};
        end
      endcase

      if (take_skid_s) begin
        m_data_r  <= skid_data_r;
        m_keep_r  <= skid_keep_r;
        m_last_r  <= skid_last_r;
        m_valid_r <= 1'b1;
      end else if (take_in_s) begin
        m_data_r  <= s_axis_tdata;
        m_keep_r  <= s_axis_tkeep;
        m_last_r  <= s_axis_tlast;
        m_valid_r <= 1'b1;
      end else if (m_hs_s) begin
        m_valid_r <= 1'b0;
      end

      if (fill_skid_s) begin
        skid_data_r <= s_axis_tdata;
        skid_keep_r <= s_axis_tkeep;
        skid_last_r <= s_axis_tlast;
      end
      skid_valid_r <= skid_valid_nxt_s;
      s_ready_r    <= ~skid_valid_nxt_s;

      if (m_hs_s) begin
        byte_count_r <= byte_count_r + popcount(m_keep_r);
        pkt_count_r  <= pkt_count_r + {{(CNT_WIDTH-1){1'b0}}, m_last_r};
      end

      if (s_hs_s && keep_bad(s_axis_tkeep, s_axis_tlast)) begin
        err_keep_r <= 1'b1;
      end
    end
  end

  assign s_axis_tready = s_ready_r;
  assign m_axis_tdata  = m_data_r;
  assign m_axis_tkeep  = m_keep_r;
  assign m_axis_tlast  = m_last_r;
  assign m_axis_tvalid = m_valid_r;
  assign pkt_count     = pkt_count_r;
  assign byte_count    = byte_count_r;
  assign err_keep      = err_keep_r;

endmodule

// File: tb/tb_axis_ifg_shaper.sv
// Scoreboard bench for axis_ifg_shaper: default build plus an 8-bit counter build sharing the stimulus.
module tb_axis_ifg_shaper;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [511:0]  s_data = '0;
  logic [63:0]   s_keep = '0;
  logic          s_last = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [511:0]  m_data;
  logic [63:0]   m_keep;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [15:0]   gap = 16'd0;
  logic [47:0]   pkt_count;
  logic [47:0]   byte_count;
  logic          err_keep;

  logic          w_s_ready;
  logic [511:0]  w_m_data;
  logic [63:0]   w_m_keep;
  logic          w_m_last;
  logic          w_m_valid;
  logic [7:0]    w_pkt_count;
  logic [7:0]    w_byte_count;
  logic          w_err_keep;

  axis_ifg_shaper dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .gap_cycles(gap), .pkt_count(pkt_count), .byte_count(byte_count), .err_keep(err_keep)
  );

  axis_ifg_shaper #(.CNT_WIDTH(8)) dut_w (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tvalid(s_valid), .s_axis_tready(w_s_ready),
    .m_axis_tdata(w_m_data), .m_axis_tkeep(w_m_keep), .m_axis_tlast(w_m_last),
    .m_axis_tvalid(w_m_valid), .m_axis_tready(m_ready),
    .gap_cycles(gap), .pkt_count(w_pkt_count), .byte_count(w_byte_count), .err_keep(w_err_keep)
  );

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  beat_t got;
  beat_t held;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    tlast_cyc = 0;
  int    last_gap = 0;
  int    rise_count = 0;
  int    ready_low = 0;
  int    rdy_mode = 0;  // 0 stall, 1 always ready, 2 random
  logic  prev_valid = 1'b0;
  logic  prev_stall = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
    else               m_ready = (rdy_mode == 1);
  end

  // Scoreboard monitor: inputs and outputs are both settled at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (m_data !== held.data || m_keep !== held.keep || m_last !== held.last || m_valid !== 1'b1) begin
          fails++;
          $display("FAIL stable: got keep=%h last=%b valid=%b, need keep=%h last=%b valid=1",
                   m_keep, m_last, m_valid, held.keep, held.last);
        end
      end
      if (m_valid && !prev_valid) begin
        rise_count++;
        last_gap = cyc - tlast_cyc;
      end
      if (!s_ready) ready_low++;
      if (s_valid && s_ready) exp_q.push_back('{s_data, s_keep, s_last});
      if (m_valid && m_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard: unexpected beat keep=%h last=%b, need none", m_keep, m_last);
        end else begin
          got = exp_q.pop_front();
          if (m_data !== got.data || m_keep !== got.keep || m_last !== got.last) begin
            fails++;
            $display("FAIL scoreboard: got keep=%h last=%b data=%h, need keep=%h last=%b data=%h",
                     m_keep, m_last, m_data[63:0], got.keep, got.last, got.data[63:0]);
          end
        end
        if (m_last) tlast_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      held       = '{m_data, m_keep, m_last};
      prev_valid = m_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    logic hs;
    int   n;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 300);
    if (!hs) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_axis_tready=0 for %0d cycles, need 1", n);
    end
  endtask

  task automatic send_pkt(input int nbytes);
    int           rem;
    logic [511:0] d;
    logic [63:0]  kk;
    rem = nbytes;
    while (rem > 0) begin
      for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
      if (rem > 64) begin
        send_beat(d, {64{1'b1}}, 1'b0);
        rem -= 64;
      end else begin
        kk = {64{1'b1}} >> (64 - rem);
        send_beat(d, kk, 1'b1);
        rem = 0;
      end
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      wait_cycles(1);
      n++;
    end
    wait_cycles(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats outstanding, need 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    tests++;
    if (m_valid !== 1'b0 || m_data !== 512'd0 || m_keep !== 64'd0 || m_last !== 1'b0 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b keep=%h last=%b ready=%b, need all 0", m_valid, m_keep, m_last, s_ready);
    end
    tests++;
    if (pkt_count !== 48'd0 || byte_count !== 48'd0 || err_keep !== 1'b0) begin
      fails++;
      $display("FAIL reset_counters: pkt=%0d bytes=%0d err=%b, need 0", pkt_count, byte_count, err_keep);
    end
    rst = 1'b0;
    wait_cycles(1);
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: s_axis_tready=%b, need 1", s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    rdy_mode = 1;
    gap = 16'd0;
    do_reset();
    r0 = rise_count;
    send_pkt(64);
    send_pkt(65);
    send_pkt(128);
    s_valid = 1'b0;
    wait_drain();
    tests++;
    if (pkt_count !== 48'd3 || byte_count !== 48'd257) begin
      fails++;
      $display("FAIL b2b_counts: pkt=%0d bytes=%0d, need 3 and 257", pkt_count, byte_count);
    end
    tests++;
    if (rise_count - r0 != 1) begin
      fails++;
      $display("FAIL b2b_bubbles: %0d valid bursts, need 1", rise_count - r0);
    end
    tests++;
    if (err_keep !== 1'b0) begin
      fails++;
      $display("FAIL b2b_err: err_keep=%b, need 0", err_keep);
    end
  endtask

  task automatic test_gap();
    int low0;
    rdy_mode = 1;
    gap = 16'd5;
    do_reset();
    low0 = ready_low;
    send_pkt(64);
    send_pkt(64);
    gap = 16'd9;  // changed mid-gap: must not affect the running gap
    s_valid = 1'b0;
    wait_drain();
    tests++;
    if (last_gap != 6) begin
      fails++;
      $display("FAIL gap_timing: next tvalid %0d cycles after tlast, need 6", last_gap);
    end
    tests++;
    if (ready_low == low0) begin
      fails++;
      $display("FAIL gap_backpressure: s_axis_tready never 0, need 0 while skid full");
    end
    tests++;
    if (pkt_count !== 48'd2) begin
      fails++;
      $display("FAIL gap_pkts: pkt=%0d, need 2", pkt_count);
    end
    wait_cycles(12);
    gap = 16'd0;
  endtask

  task automatic test_random_ready();
    gap = 16'd0;
    do_reset();
    rdy_mode = 2;
    send_pkt(640);
    s_valid = 1'b0;
    wait_drain();
    rdy_mode = 1;
    tests++;
    if (pkt_count !== 48'd1 || byte_count !== 48'd640) begin
      fails++;
      $display("FAIL random_counts: pkt=%0d bytes=%0d, need 1 and 640", pkt_count, byte_count);
    end
  endtask

  task automatic test_keep_err();
    rdy_mode = 1;
    gap = 16'd0;
    do_reset();
    send_beat({16{32'hA5A5_0001}}, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    tests++;
    if (err_keep !== 1'b1) begin
      fails++;
      $display("FAIL keep_err_set: err_keep=%b, need 1", err_keep);
    end
    send_beat({16{32'h5A5A_0002}}, 64'h5, 1'b1);
    s_valid = 1'b0;
    wait_drain();
    tests++;
    if (err_keep !== 1'b1) begin
      fails++;
      $display("FAIL keep_err_sticky: err_keep=%b, need 1", err_keep);
    end
    tests++;
    if (byte_count !== 48'd65 || pkt_count !== 48'd1) begin
      fails++;
      $display("FAIL keep_err_fwd: pkt=%0d bytes=%0d, need 1 and 65", pkt_count, byte_count);
    end
  endtask

  task automatic test_reset_mid();
    for (int v = 0; v < 2; v++) begin
      gap = 16'd0;
      rdy_mode = 1;
      do_reset();
      if (v == 0) begin
        rdy_mode = 0;
        wait_cycles(1);
        send_beat({16{32'h1111_0000}}, {64{1'b1}}, 1'b0);
        send_beat({16{32'h2222_0000}}, {64{1'b1}}, 1'b0);
      end else begin
        gap = 16'd10;
        send_pkt(64);
        send_beat({16{32'h3333_0000}}, {64{1'b1}}, 1'b1);
        s_valid = 1'b0;
        wait_cycles(3);
        tests++;
        if (pkt_count !== 48'd1) begin
          fails++;
          $display("FAIL midgap_pre: pkt=%0d, need 1", pkt_count);
        end
      end
      s_valid = 1'b0;
      rst = 1'b1;
      wait_cycles(1);
      tests++;
      if (m_valid !== 1'b0 || m_data !== 512'd0 || m_keep !== 64'd0 || s_ready !== 1'b0 ||
          pkt_count !== 48'd0 || byte_count !== 48'd0) begin
        fails++;
        $display("FAIL midreset_%0d: valid=%b keep=%h ready=%b pkt=%0d bytes=%0d, need all 0",
                 v, m_valid, m_keep, s_ready, pkt_count, byte_count);
      end
      rst = 1'b0;
      rdy_mode = 1;
      gap = 16'd0;
      wait_cycles(1);
      send_beat({16{32'h4444_0000}} ^ 512'(v), {64{1'b1}}, 1'b1);
      s_valid = 1'b0;
      tests++;
      if (m_valid !== 1'b1 || m_last !== 1'b1) begin
        fails++;
        $display("FAIL postreset_latency_%0d: valid=%b last=%b, need 1 and 1", v, m_valid, m_last);
      end
      wait_drain();
      tests++;
      if (pkt_count !== 48'd1 || byte_count !== 48'd64) begin
        fails++;
        $display("FAIL postreset_counts_%0d: pkt=%0d bytes=%0d, need 1 and 64", v, pkt_count, byte_count);
      end
    end
  endtask

  task automatic test_wrap();
    rdy_mode = 1;
    gap = 16'd0;
    do_reset();
    send_pkt(300);
    s_valid = 1'b0;
    wait_drain();
    tests++;
    if (w_byte_count !== 8'd44 || w_pkt_count !== 8'd1) begin
      fails++;
      $display("FAIL wrap_narrow: bytes=%0d pkt=%0d, need 44 and 1", w_byte_count, w_pkt_count);
    end
    tests++;
    if (byte_count !== 48'd300) begin
      fails++;
      $display("FAIL wrap_wide: bytes=%0d, need 300", byte_count);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_random_ready();
    test_keep_err();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
